vga_frame_reader: RTL

Scan-out stage between the VGA timing and the framebuffer ROM/RAM. Generates 640x480@60 sync timing from the pixel clock and drives the framebuffer read address with integer pixel scaling. Consumes the memory's registered read data and delivers RGB332 colour, hsync and vsync to the DAC pins with all outputs mutually aligned.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_timing.sv | 55 +++++
 rtl/vga_frame_reader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA scan-out definitions: default 640x480@60 timing and RGB332 pixel format.
package vga_pkg;

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;
    localparam int DEF_SCALE_SHIFT = 3;
    localparam int DEF_ADDR_WIDTH  = 13;
    localparam int PIXEL_WIDTH     = 8;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    function automatic rgb332_t unpack_rgb(input logic [PIXEL_WIDTH-1:0] word);
        rgb332_t pix;
        pix.r = word[7:5];
        pix.g = word[4:2];
        pix.b = word[1:0];
        return pix;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with active, sync and first-pixel decode.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [HW-1:0] h_cnt,
    output logic          active,
    output logic          line_vis,
    output logic          h_wrap,
    output logic          frame_end,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          first
);

    logic [VW-1:0] v_cnt;

    assign h_wrap    = h_cnt == HW'(H_TOTAL - 1);
    assign frame_end = v_cnt == VW'(V_TOTAL - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign line_vis = v_cnt < VW'(V_ACTIVE);
    assign active   = (h_cnt < HW'(H_ACTIVE)) && line_vis;
    assign hsync_n  = !((h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                        (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vsync_n  = !((v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                        (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign first    = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_frame_reader.sv
// VGA scan-out: raster timing, scaled framebuffer addressing and a
// pipeline that keeps colour, syncs and frame_start aligned at the pins.
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = PIXEL_WIDTH,
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int HW         = $clog2(H_TOTAL)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_write,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [2:0]            o_red,
    output logic [2:0]            o_green,
    output logic [1:0]            o_blue,
    output logic                  o_hsync,
    output logic                  o_vsync,
    output logic                  o_frame_start
);

    localparam int ROW_STEP = H_ACTIVE >> SCALE_SHIFT;

    logic [HW-1:0] h_cnt;
    logic          active;
    logic          line_vis;
    logic          h_wrap;
    logic          frame_end;
    logic          hsync_n;
    logic          vsync_n;
    logic          first;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) timing (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .h_cnt     (h_cnt),
        .active    (active),
        .line_vis  (line_vis),
        .h_wrap    (h_wrap),
        .frame_end (frame_end),
        .hsync_n   (hsync_n),
        .vsync_n   (vsync_n),
        .first     (first)
    );

    logic [ADDR_WIDTH-1:0]  row_base;
    logic [SCALE_SHIFT-1:0] sub_row;

    assign o_write = 1'b0;
    assign o_addr  = active ? row_base + ADDR_WIDTH'(h_cnt >> SCALE_SHIFT) : '0;

    // row_base steps one framebuffer row after every 2^SCALE_SHIFT visible lines
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_base <= '0;
            sub_row  <= '0;
        end else if (h_wrap) begin
            if (frame_end) begin
                row_base <= '0;
                sub_row  <= '0;
            end else if (line_vis) begin
                sub_row <= sub_row + 1'b1;
                if (&sub_row)
                    row_base <= row_base + ADDR_WIDTH'(ROW_STEP);
            end
        end
    end

    logic act_d;
    logic hs_d;
    logic vs_d;
    logic first_d;

    // first stage matches the memory's one-cycle read latency
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            act_d   <= 1'b0;
            hs_d    <= 1'b1;
            vs_d    <= 1'b1;
            first_d <= 1'b0;
        end else begin
            act_d   <= active;
            hs_d    <= hsync_n;
            vs_d    <= vsync_n;
            first_d <= first;
        end
    end

    rgb332_t pix;
    assign pix = unpack_rgb(i_data);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_red         <= '0;
            o_green       <= '0;
            o_blue        <= '0;
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_frame_start <= 1'b0;
        end else begin
            o_red         <= act_d ? pix.r : '0;
            o_green       <= act_d ? pix.g : '0;
            o_blue        <= act_d ? pix.b : '0;
            o_hsync       <= hs_d;
            o_vsync       <= vs_d;
            o_frame_start <= first_d;
        end
    end

endmodule
